// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 read-command arbiter: FSM states,
// default widths/timeout and the command-word width derivation.
package tlk2711_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_WIDTH     = 48;
  localparam int DEF_DLEN_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int TO_CNT_WIDTH       = 16;

  // Command word is {length, address}.
  function automatic int calc_cw(input int dlen_w, input int addr_w);
    return dlen_w + addr_w;
  endfunction

endpackage

// File: rtl/tlk2711_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that was not
// granted last wins. Purely combinational, one-hot grant.
module tlk2711_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last_gnt ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/tlk2711_rd_cmd_arb.sv
// Arbitrates two requesters onto one DMA read-command channel and routes the
// returning read stream back to the owner until its last beat or a timeout.
module tlk2711_rd_cmd_arb
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DLEN_WIDTH     = DEF_DLEN_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_soft_rst,
  input  logic                                       i_req0_cmd_req,
  input  logic [calc_cw(DLEN_WIDTH, ADDR_WIDTH)-1:0] i_req0_cmd_data,
  output logic                                       o_req0_cmd_ack,
  input  logic                                       i_req1_cmd_req,
  input  logic [calc_cw(DLEN_WIDTH, ADDR_WIDTH)-1:0] i_req1_cmd_data,
  output logic                                       o_req1_cmd_ack,
  output logic                                       o_rd_cmd_req,
  output logic [calc_cw(DLEN_WIDTH, ADDR_WIDTH)-1:0] o_rd_cmd_data,
  input  logic                                       i_rd_cmd_ack,
  input  logic                                       i_dma_rd_valid,
  input  logic                                       i_dma_rd_last,
  input  logic [DATA_WIDTH-1:0]                      i_dma_rd_data,
  output logic                                       o_dma_rd_ready,
  output logic                                       o_req0_rd_valid,
  output logic                                       o_req0_rd_last,
  output logic [DATA_WIDTH-1:0]                      o_req0_rd_data,
  input  logic                                       i_req0_rd_ready,
  output logic                                       o_req1_rd_valid,
  output logic                                       o_req1_rd_last,
  output logic [DATA_WIDTH-1:0]                      o_req1_rd_data,
  input  logic                                       i_req1_rd_ready,
  output logic [1:0]                                 o_grant,
  output logic                                       o_busy,
  output logic                                       o_timeout_err
);

  localparam int CW = calc_cw(DLEN_WIDTH, ADDR_WIDTH);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [1:0]              r_grant;
  logic [1:0]              r_cmd_ack;
  logic [CW-1:0]           r_cmd_data;
  logic [TO_CNT_WIDTH-1:0] r_to_cnt;
  logic                    r_timeout_err;
  logic                    r_last_gnt;

  logic       w_rst;
  logic [1:0] w_req;
  logic [1:0] w_arb_gnt;
  logic       w_in_data;
  logic       w_owner_ready;
  logic       w_hs;
  logic       w_done;
  logic       w_tmo;

  assign w_rst = rst | i_soft_rst;
  assign w_req = {i_req1_cmd_req, i_req0_cmd_req};

  tlk2711_rr_arb2 u_rr_arb (
    .i_req      (w_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_arb_gnt)
  );

  assign w_in_data     = (r_state == ST_DATA);
  assign w_owner_ready = r_grant[1] ? i_req1_rd_ready : i_req0_rd_ready;
  assign w_hs          = w_in_data & i_dma_rd_valid & w_owner_ready;
  assign w_done        = w_hs & i_dma_rd_last;
  // Counter holds the number of idle DATA cycles already seen, so this
  // cycle being idle too is the one that reaches the limit.
  assign w_tmo         = w_in_data & ~w_hs & (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (|w_req)         w_state_nxt = ST_CMD;
      ST_CMD:  if (i_rd_cmd_ack)   w_state_nxt = ST_DATA;
      ST_DATA: if (w_done || w_tmo) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_grant       <= '0;
      r_cmd_ack     <= '0;
      r_cmd_data    <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_last_gnt    <= 1'b1;
    end else begin
      r_cmd_ack <= '0;
      unique case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (|w_req) begin
            r_grant    <= w_arb_gnt;
            r_cmd_data <= w_arb_gnt[1] ? i_req1_cmd_data : i_req0_cmd_data;
          end
        end
        ST_CMD: begin
          if (i_rd_cmd_ack) r_cmd_ack <= r_grant;
        end
        ST_DATA: begin
          if (w_hs) r_to_cnt <= '0;
          else      r_to_cnt <= r_to_cnt + 1'b1;
          if (w_done) begin
            r_last_gnt <= r_grant[1];
            r_grant    <= '0;
            r_to_cnt   <= '0;
          end
          if (w_tmo) begin
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_to_cnt      <= '0;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign o_req0_cmd_ack  = r_cmd_ack[0];
  assign o_req1_cmd_ack  = r_cmd_ack[1];
  assign o_rd_cmd_req    = (r_state == ST_CMD);
  assign o_rd_cmd_data   = r_cmd_data;
  assign o_dma_rd_ready  = w_in_data & w_owner_ready;
  assign o_req0_rd_valid = w_in_data & r_grant[0] & i_dma_rd_valid;
  assign o_req1_rd_valid = w_in_data & r_grant[1] & i_dma_rd_valid;
  assign o_req0_rd_last  = w_in_data & r_grant[0] & i_dma_rd_last;
  assign o_req1_rd_last  = w_in_data & r_grant[1] & i_dma_rd_last;
  assign o_req0_rd_data  = i_dma_rd_data;
  assign o_req1_rd_data  = i_dma_rd_data;
  assign o_grant         = r_grant;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_tlk2711_rd_cmd_arb.sv
// Directed bench for tlk2711_rd_cmd_arb with hand-computed expectations.
module tb_tlk2711_rd_cmd_arb;

  logic        clk = 1'b0;
  logic        rst, i_soft_rst;
  logic        i_req0_cmd_req, i_req1_cmd_req;
  logic [63:0] i_req0_cmd_data, i_req1_cmd_data;
  logic        o_req0_cmd_ack, o_req1_cmd_ack;
  logic        o_rd_cmd_req;
  logic [63:0] o_rd_cmd_data;
  logic        i_rd_cmd_ack;
  logic        i_dma_rd_valid, i_dma_rd_last;
  logic [63:0] i_dma_rd_data;
  logic        o_dma_rd_ready;
  logic        o_req0_rd_valid, o_req0_rd_last, o_req1_rd_valid, o_req1_rd_last;
  logic [63:0] o_req0_rd_data, o_req1_rd_data;
  logic        i_req0_rd_ready, i_req1_rd_ready;
  logic [1:0]  o_grant;
  logic        o_busy, o_timeout_err;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] D0 = 64'h0100_0000_0000_1000;
  localparam logic [63:0] D1 = 64'h0040_0000_ABCD_2000;
  localparam logic [63:0] D2 = 64'h0008_0000_0000_3000;
  localparam logic [63:0] D3 = 64'h0010_1234_5678_4000;
  localparam logic [63:0] D4 = 64'h0020_0000_0000_5000;

  tlk2711_rd_cmd_arb #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_soft_rst      (i_soft_rst),
    .i_req0_cmd_req  (i_req0_cmd_req),
    .i_req0_cmd_data (i_req0_cmd_data),
    .o_req0_cmd_ack  (o_req0_cmd_ack),
    .i_req1_cmd_req  (i_req1_cmd_req),
    .i_req1_cmd_data (i_req1_cmd_data),
    .o_req1_cmd_ack  (o_req1_cmd_ack),
    .o_rd_cmd_req    (o_rd_cmd_req),
    .o_rd_cmd_data   (o_rd_cmd_data),
    .i_rd_cmd_ack    (i_rd_cmd_ack),
    .i_dma_rd_valid  (i_dma_rd_valid),
    .i_dma_rd_last   (i_dma_rd_last),
    .i_dma_rd_data   (i_dma_rd_data),
    .o_dma_rd_ready  (o_dma_rd_ready),
    .o_req0_rd_valid (o_req0_rd_valid),
    .o_req0_rd_last  (o_req0_rd_last),
    .o_req0_rd_data  (o_req0_rd_data),
    .i_req0_rd_ready (i_req0_rd_ready),
    .o_req1_rd_valid (o_req1_rd_valid),
    .o_req1_rd_last  (o_req1_rd_last),
    .o_req1_rd_data  (o_req1_rd_data),
    .i_req1_rd_ready (i_req1_rd_ready),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_timeout_err   (o_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bd(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Entered while the DUT sits in CMD with owner eg; ends in the IDLE cycle
  // after the last beat.
  task automatic run_txn(input logic [1:0] eg, input logic [63:0] ed, input int nb, input int hold);
    logic [6:0] e;
    chk("txn_grant", o_grant, eg);
    chk("txn_cmd_req", o_rd_cmd_req, 1'b1);
    chk("txn_cmd_data", o_rd_cmd_data, ed);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("txn_hold", {o_rd_cmd_req, o_req1_cmd_ack, o_req0_cmd_ack}, 3'b100);
    end
    i_req0_rd_ready = 1'b1;
    i_req1_rd_ready = 1'b1;
    i_rd_cmd_ack = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b0;
    if (eg[0]) i_req0_cmd_req = 1'b0;
    else       i_req1_cmd_req = 1'b0;
    chk("txn_cmd_req_drop", o_rd_cmd_req, 1'b0);
    for (int b = 0; b < nb; b++) begin
      i_dma_rd_valid = 1'b1;
      i_dma_rd_last  = (b == nb - 1);
      i_dma_rd_data  = bd(b);
      #1;
      e = {(b == 0) ? eg : 2'b00, eg, 1'b1, (b == nb - 1) ? eg : 2'b00};
      chk("txn_beat", {o_req1_cmd_ack, o_req0_cmd_ack, o_req1_rd_valid, o_req0_rd_valid,
                       o_dma_rd_ready, o_req1_rd_last, o_req0_rd_last}, e);
      chk("txn_data", eg[1] ? o_req1_rd_data : o_req0_rd_data, bd(b));
      tick();
    end
    i_dma_rd_valid = 1'b0;
    i_dma_rd_last  = 1'b0;
    chk("txn_end_idle", {o_busy, o_grant, o_rd_cmd_req}, 4'b0000);
  endtask

  initial begin
    logic [15:0] pat;
    logic        r;
    int          k;

    rst = 1'b1; i_soft_rst = 1'b0;
    i_req0_cmd_req = 1'b0; i_req1_cmd_req = 1'b0;
    i_req0_cmd_data = '0; i_req1_cmd_data = '0;
    i_rd_cmd_ack = 1'b0;
    i_dma_rd_valid = 1'b0; i_dma_rd_last = 1'b0; i_dma_rd_data = '0;
    i_req0_rd_ready = 1'b0; i_req1_rd_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_flags", {o_grant, o_busy, o_rd_cmd_req, o_timeout_err, o_req1_cmd_ack,
                      o_req0_cmd_ack, o_dma_rd_ready}, 8'h00);
    chk("rst_cmd_data", o_rd_cmd_data, 64'h0);

    // Single requester, 32 beats, command held for two cycles before ack
    i_req0_cmd_req = 1'b1; i_req0_cmd_data = D0;
    i_req1_cmd_data = D1;
    tick();
    chk("r0_busy", o_busy, 1'b1);
    run_txn(2'b01, D0, 32, 2);

    // Round-robin with ties in both directions and back-to-back latency
    do_reset();
    i_req0_cmd_req = 1'b1; i_req1_cmd_req = 1'b1;
    tick();
    run_txn(2'b01, D0, 4, 0);
    i_req0_cmd_req = 1'b1;
    tick();
    run_txn(2'b10, D1, 4, 0);
    i_req1_cmd_req = 1'b1;
    tick();
    run_txn(2'b01, D0, 3, 0);
    tick();
    run_txn(2'b10, D1, 2, 0);

    // Owner ready toggling; the other requester's ready is the inverse
    pat = 16'b0110_1001_1100_1010;
    i_req0_cmd_data = D2; i_req0_cmd_req = 1'b1;
    tick();
    chk("tg_cmd_data", o_rd_cmd_data, D2);
    i_rd_cmd_ack = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b0; i_req0_cmd_req = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      r = pat[cyc % 16];
      i_req0_rd_ready = r; i_req1_rd_ready = ~r;
      i_dma_rd_valid = 1'b1; i_dma_rd_last = (k == 7); i_dma_rd_data = bd(k);
      #1;
      chk("tg_ready_valid", {o_dma_rd_ready, o_req0_rd_valid, o_req1_rd_valid, o_busy}, {r, 3'b101});
      chk("tg_data", o_req0_rd_data, bd(k));
      tick();
      if (r) k++;
    end
    i_dma_rd_valid = 1'b0; i_dma_rd_last = 1'b0;
    chk("tg_beats_done", 64'(k), 64'd8);
    chk("tg_idle", o_busy, 1'b0);

    // Idle counter clears on a handshake: 12 + 12 idle cycles, no timeout
    i_req0_rd_ready = 1'b1; i_req0_cmd_req = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b0; i_req0_cmd_req = 1'b0;
    repeat (12) tick();
    i_dma_rd_valid = 1'b1;
    tick();
    i_dma_rd_valid = 1'b0;
    repeat (12) tick();
    chk("clr_mid", {o_timeout_err, o_busy}, 2'b01);
    i_dma_rd_valid = 1'b1; i_dma_rd_last = 1'b1;
    tick();
    i_dma_rd_valid = 1'b0; i_dma_rd_last = 1'b0;
    chk("clr_end", {o_timeout_err, o_busy}, 2'b00);

    // Stalled stream times out after 16 idle DATA cycles; pending req1 waits
    i_req0_cmd_data = D3; i_req0_cmd_req = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b0; i_req0_cmd_req = 1'b0;
    i_req1_cmd_data = D4; i_req1_cmd_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_wait", {o_timeout_err, o_busy, o_grant}, 4'b0101);
    end
    tick();
    chk("to_hit", {o_timeout_err, o_busy, o_grant}, 4'b1000);
    tick();
    chk("to_next_grant", {o_timeout_err, o_rd_cmd_req, o_grant}, 4'b1110);
    chk("to_next_data", o_rd_cmd_data, D4);

    // Soft reset in DATA drops everything, including the sticky error
    i_rd_cmd_ack = 1'b1;
    tick();
    i_rd_cmd_ack = 1'b0; i_req1_cmd_req = 1'b0;
    chk("srst_pre", {o_busy, o_grant, o_timeout_err}, 4'b1101);
    i_soft_rst = 1'b1;
    tick();
    chk("srst_flags", {o_grant, o_busy, o_rd_cmd_req, o_timeout_err, o_req1_cmd_ack,
                       o_req0_cmd_ack, o_dma_rd_ready}, 8'h00);
    chk("srst_cmd_data", o_rd_cmd_data, 64'h0);
    i_soft_rst = 1'b0;
    i_req0_cmd_req = 1'b1; i_req1_cmd_req = 1'b1;
    tick();
    chk("srst_tie_req0", o_grant, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
